bitonic_sort_pipe: RTL and testbench
====================================

Name: bitonic_sort_pipe

Overview:
Parametrised, fully pipelined bitonic sorting network. It accepts one vector of DEPTH unsigned WIDTH-bit keys per cycle under a valid/ready handshake and emits the sorted vector a fixed number of cycles later. A per-vector direction bit selects ascending or descending order. It replaces the fixed 8-entry, 3-stage sorter in the sort datapath and adds backpressure and direction control.

Parameters:
WIDTH, 32, key width in bits (>=1)
DEPTH, 8, keys per vector; power of two, 2..64; elaboration error otherwise
LOG2D, $clog2(DEPTH), derived, not overridable
LAYERS, LOG2D*(LOG2D+1)/2, derived; compare-exchange layers (6 for DEPTH=8)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector this cycle
in_desc  input  1  0 = ascending (element 0 smallest), 1 = descending
in_data  input  WIDTH*DEPTH  keys; element i = in_data[i*WIDTH +: WIDTH]
out_valid  output  1  sorted vector valid
out_ready  input  1  downstream accepts the vector
out_desc  output  1  direction bit travelling with the vector
out_data  output  WIDTH*DEPTH  sorted keys, same packing as in_data
busy  output  1  any pipeline layer holds a valid vector

Behaviour:
- Reset: sync, active-high. On the clk edge with rst=1, all layer valid bits clear. Registered outputs after reset: out_valid=0, out_data=0, out_desc=0, busy=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded. No partial vector is ever presented.
- Structure: LAYERS register layers. Each layer = one compare-exchange column of the standard bitonic network, followed by registers for data, desc and valid.
  - Merge phase p runs 1..LOG2D; sub-step s runs p-1 down to 0; partner of i = i XOR (1<<s).
  - Pair direction = ascending if bit p of i is 0, else descending. Phase p=LOG2D is always ascending.
  - When desc=1, every pair direction is inverted.
- Compare: unsigned, full WIDTH. Equal keys are not swapped, so output is deterministic but not stable.
- Latency: LAYERS cycles from an accepted input to out_valid, with no stall. Input accepted at edge k gives out_valid high after edge k+LAYERS.
- Throughput: one vector per cycle when out_ready=1.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - A transfer occurs on an edge where in_valid && in_ready.
  - When adv=0, all layers hold their contents and in_ready=0.
  - When adv=1 and there is no transfer, a bubble (valid=0) enters layer 0.
  - Bubbles are not compressed.
- Output side: out_data/out_desc stay stable while out_valid && !out_ready. in_valid may drop without loss once it has been accepted.
- Simultaneous accept and output: with out_valid=1 and out_ready=1, an input presented that cycle is accepted in the same cycle.
- busy = OR of all layer valid bits, including the output layer.
- in_data and in_desc of bubbles are don't-care. Invalid layer data does not need to be zeroed, except on reset.

Optional Feature:
Macro BITONIC_SIGNED_EN.
- Defined: keys are compared as two's-complement signed values.
- Undefined: unsigned compare (default).
- No port or latency change either way.

Test Plan:
- DEPTH=8, WIDTH=32, in_desc=0, in_data={5,3,7,1,8,2,6,4} (elem0..7), out_ready=1 -> after exactly 6 cycles, out_valid=1 with out_data={1,2,3,4,5,6,7,8} for one cycle; busy falls the next cycle.
- Same vector with in_desc=1 -> out_data={8,7,6,5,4,3,2,1}, out_desc=1.
- Back-to-back streaming of 10 random vectors with alternating desc and out_ready=1 -> 10 consecutive out_valid cycles, each matching the reference model; in_ready stays 1 throughout.
- Hold out_ready=0 while 6+ vectors are in flight -> in_ready=0, out_data stable, no loss or duplication; release -> the vectors drain in order.
- Duplicates and boundaries: {FFFFFFFF,0,0,FFFFFFFF,1,1,80000000,7FFFFFFF} ascending -> {0,0,1,1,7FFFFFFF,80000000,FFFFFFFF,FFFFFFFF}. With BITONIC_SIGNED_EN defined -> {80000000,FFFFFFFF,FFFFFFFF,0,0,1,1,7FFFFFFF}.
- Assert rst for 1 cycle while 3 vectors are in flight -> out_valid=0, busy=0, out_data=0; the next input emerges after 6 cycles and is correct. Repeat the first scenario at DEPTH=2 (latency 1) and DEPTH=16 (latency 10).

Source files
------------

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: fully pipelined bitonic sorting network.
// Accepts one vector of DEPTH keys per cycle under valid/ready and returns it
// sorted LAYERS cycles later, ascending or descending per vector.
// One register layer follows every compare-exchange column. A single global
// advance enable stalls the whole pipe.
// Optional build macro BITONIC_SIGNED_EN: compare keys as two's-complement
// signed values instead of unsigned.
module bitonic_sort_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_desc,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_desc,
  output logic [WIDTH*DEPTH-1:0] out_data,
  output logic                   busy
);

  localparam int LOG2D  = $clog2(DEPTH);
  localparam int LAYERS = LOG2D * (LOG2D + 1) / 2;
  localparam int DW     = WIDTH * DEPTH;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bitonic_sort_pipe: DEPTH must be a power of two in 2..64");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("bitonic_sort_pipe: WIDTH must be at least 1");
  end

  // Stage k is the input of layer k; stage LAYERS is the output register.
  logic [DW-1:0]   stg_data [LAYERS+1];
  logic [LAYERS:0] stg_desc;
  logic [LAYERS:0] stg_valid;
  logic            adv;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign adv          = !out_valid || out_ready;
  assign in_ready     = adv;
  assign stg_data[0]  = in_data;
  assign stg_desc[0]  = in_desc;
  assign stg_valid[0] = in_valid;

  assign out_valid = stg_valid[LAYERS];
  assign out_desc  = stg_desc[LAYERS];
  assign out_data  = stg_data[LAYERS];
  assign busy      = |stg_valid[LAYERS:1];

  // Merge phase p builds sorted blocks of 2**p; sub-step s compares i with i^(1<<s).
  for (genvar p = 1; p <= LOG2D; p++) begin : g_phase
    for (genvar k = 0; k < p; k++) begin : g_step
      localparam int S = p - 1 - k;
      localparam int L = p * (p - 1) / 2 + k;

      logic [DW-1:0] cx;
      logic [DW-1:0] data_q;
      logic          desc_q;
      logic          valid_q;

      for (genvar i = 0; i < DEPTH; i++) begin : g_pair
        if (((i >> S) & 1) == 0) begin : g_cx
          localparam int J  = i + (1 << S);
          // Block direction from bit p of the lower index; the last phase is always ascending.
          localparam bit UP = ((i >> p) & 1) == 0;

          logic [WIDTH-1:0] a;
          logic [WIDTH-1:0] b;
          logic             gt;
          logic             lt;
          logic             asc;
          logic             swap;

          assign a = stg_data[L][i*WIDTH +: WIDTH];
          assign b = stg_data[L][J*WIDTH +: WIDTH];
`ifdef BITONIC_SIGNED_EN
          assign gt = $signed(a) > $signed(b);
          assign lt = $signed(a) < $signed(b);
`else
          assign gt = a > b;
          assign lt = a < b;
`endif
          // A descending vector flips every pair; equal keys never swap.
          assign asc  = UP ^ stg_desc[L];
          assign swap = asc ? gt : lt;
          assign cx[i*WIDTH +: WIDTH] = swap ? b : a;
          assign cx[J*WIDTH +: WIDTH] = swap ? a : b;
        end
      end

      // Layer register: load on advance, hold on stall, clear on reset.
      always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every layer sampling the previous
        // layer's old value on the same edge, which is what makes this a pipeline.
        if (rst) begin
          valid_q <= 1'b0;
          desc_q  <= 1'b0;
          // NOTE: data is cleared too because out_data must read zero after
          // reset; otherwise payload registers would not need a reset.
          data_q  <= '0;
        end else if (adv) begin
          valid_q <= stg_valid[L];
          desc_q  <= stg_desc[L];
          data_q  <= cx;
        end
      end

      assign stg_data[L+1]  = data_q;
      assign stg_desc[L+1]  = desc_q;
      assign stg_valid[L+1] = valid_q;
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench for bitonic_sort_pipe: table of directed vectors,
// streaming, output stall, mid-flight reset, and DEPTH=2 / DEPTH=16 builds.
module tb_bitonic_sort_pipe;

  localparam int LAT8  = 6;
  localparam int LAT2  = 1;
  localparam int LAT16 = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic         in_valid, in_ready, in_desc, out_valid, out_ready, out_desc, busy;
  logic [255:0] in_data, out_data;
  // DEPTH=2 instance
  logic         d2_in_valid, d2_in_ready, d2_in_desc, d2_out_valid, d2_out_desc, d2_busy;
  logic [63:0]  d2_in_data, d2_out_data;
  // DEPTH=16 instance
  logic         d16_in_valid, d16_in_ready, d16_in_desc, d16_out_valid, d16_out_desc, d16_busy;
  logic [511:0] d16_in_data, d16_out_data;

  bitonic_sort_pipe #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_desc(out_desc),
    .out_data(out_data), .busy(busy));

  bitonic_sort_pipe #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_desc(d2_in_desc),
    .in_data(d2_in_data), .out_valid(d2_out_valid), .out_ready(1'b1), .out_desc(d2_out_desc),
    .out_data(d2_out_data), .busy(d2_busy));

  bitonic_sort_pipe #(.WIDTH(32), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready), .in_desc(d16_in_desc),
    .in_data(d16_in_data), .out_valid(d16_out_valid), .out_ready(1'b1), .out_desc(d16_out_desc),
    .out_data(d16_out_data), .busy(d16_busy));

  typedef struct {
    logic [255:0] data;
    logic         desc;
    logic [255:0] exp;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    logic         desc;
    int           acc;
  } sb_t;

  vec_t         tab[6];
  sb_t          sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           pops   = 0;
  logic         lat_chk;
  logic         use_tab;
  logic [255:0] tab_exp;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack8(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic key_gt(input logic [31:0] a, input logic [31:0] b);
`ifdef BITONIC_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference: plain bubble sort, then reverse for descending.
  function automatic logic [255:0] model8(input logic [255:0] d, input logic desc);
    logic [31:0]  k[8];
    logic [31:0]  t;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) k[i] = d[i*32 +: 32];
    for (int n = 0; n < 8; n++)
      for (int j = 0; j < 7; j++)
        if (key_gt(k[j], k[j+1])) begin
          t = k[j]; k[j] = k[j+1]; k[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = desc ? k[7-i] : k[i];
    return r;
  endfunction

  // One clock of the DEPTH=8 DUT: score the output handshake and record an
  // input transfer for the coming edge, then step past the edge.
  task automatic cycle();
    sb_t e;
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("out_data", out_data, sb_q[0].data);
          check("out_desc", out_desc, sb_q[0].desc);
          if (out_ready) begin
            if (lat_chk) check("latency", cyc - sb_q[0].acc, LAT8);
            void'(sb_q.pop_front());
            pops++;
          end else begin
            check("in_ready_stalled", in_ready, 1'b0);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data = use_tab ? tab_exp : model8(in_data, in_desc);
        e.desc = in_desc;
        e.acc  = cyc;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) sb_q.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic run_d2(input logic [63:0] d, input logic desc, input logic [63:0] exp);
    int n;
    d2_in_data = d; d2_in_desc = desc; d2_in_valid = 1'b1;
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    n = 1;
    while (!d2_out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("d2_latency", n, LAT2);
    check("d2_out_data", d2_out_data, exp);
    check("d2_out_desc", d2_out_desc, desc);
    @(posedge clk); #1;
    check("d2_idle", {d2_out_valid, d2_busy}, 2'b00);
  endtask

  task automatic run_d16(input logic [511:0] d, input logic desc, input logic [511:0] exp);
    int n;
    d16_in_data = d; d16_in_desc = desc; d16_in_valid = 1'b1;
    @(posedge clk); #1;
    d16_in_valid = 1'b0;
    n = 1;
    while (!d16_out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("d16_latency", n, LAT16);
    check("d16_out_data", d16_out_data, exp);
    check("d16_out_desc", d16_out_desc, desc);
    @(posedge clk); #1;
    check("d16_idle", {d16_out_valid, d16_busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] v16;
    logic [511:0] e16;
    int           p0;
    int           c0;
    int           t;
    logic         acc;

    rst = 1'b1; in_valid = 1'b0; in_desc = 1'b0; in_data = '0; out_ready = 1'b1;
    d2_in_valid = 1'b0; d2_in_desc = 1'b0; d2_in_data = '0;
    d16_in_valid = 1'b0; d16_in_desc = 1'b0; d16_in_data = '0;
    lat_chk = 1'b1; use_tab = 1'b0; tab_exp = '0;

    tab[0] = '{pack8(5, 3, 7, 1, 8, 2, 6, 4), 1'b0, pack8(1, 2, 3, 4, 5, 6, 7, 8)};
    tab[1] = '{pack8(5, 3, 7, 1, 8, 2, 6, 4), 1'b1, pack8(8, 7, 6, 5, 4, 3, 2, 1)};
    tab[2].data = pack8(32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 1, 1, 32'h80000000, 32'h7FFFFFFF);
    tab[2].desc = 1'b0;
    tab[3].data = tab[2].data;
    tab[3].desc = 1'b1;
`ifdef BITONIC_SIGNED_EN
    tab[2].exp = pack8(32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 1, 32'h7FFFFFFF);
    tab[3].exp = pack8(32'h7FFFFFFF, 1, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000);
`else
    tab[2].exp = pack8(0, 0, 1, 1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tab[3].exp = pack8(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1, 1, 0, 0);
`endif
    tab[4] = '{{8{32'hA5A5A5A5}}, 1'b1, {8{32'hA5A5A5A5}}};
    tab[5] = '{pack8(8, 7, 6, 5, 4, 3, 2, 1), 1'b0, pack8(1, 2, 3, 4, 5, 6, 7, 8)};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_desc", out_desc, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_d2_d16_valid", {d2_out_valid, d16_out_valid}, 2'b00);

    // Directed vectors, one at a time, exact latency and single-cycle output
    use_tab = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = tab[i].data; in_desc = tab[i].desc; tab_exp = tab[i].exp;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      drain(20);
      check("single_out_valid_drop", out_valid, 1'b0);
      check("single_busy_drop", busy, 1'b0);
    end
    use_tab = 1'b0;

    // Back-to-back streaming, alternating direction
    p0 = pops;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom();
      in_desc  = v[0];
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    drain(20);
    check("stream_count", pops - p0, 10);

    // Output stall with the pipe full, then release
    lat_chk = 1'b0;
    out_ready = 1'b0;
    p0 = pops;
    c0 = cyc;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom_range(0, 15);
      in_desc  = v[1];
      in_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
        if (cyc - c0 >= 14) out_ready = 1'b1;
        #1;
        acc = in_ready;
        cycle();
        t++;
      end
      check("stall_accepted", acc, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(30);
    check("stall_count", pops - p0, 10);
    lat_chk = 1'b1;

    // Reset with three vectors in flight
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom();
      in_desc = 1'b0; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    use_tab = 1'b1;
    in_data = tab[0].data; in_desc = tab[0].desc; tab_exp = tab[0].exp;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain(20);
    use_tab = 1'b0;
    repeat (4) cycle();

    // DEPTH=2
    run_d2({32'd4, 32'd9}, 1'b0, {32'd9, 32'd4});
    run_d2({32'd4, 32'd9}, 1'b1, {32'd4, 32'd9});

    // DEPTH=16: element i = (7*i+3) mod 16, a permutation of 0..15
    for (int i = 0; i < 16; i++) begin
      v16[i*32 +: 32] = (7 * i + 3) % 16;
      e16[i*32 +: 32] = i;
    end
    run_d16(v16, 1'b0, e16);
    for (int i = 0; i < 16; i++) e16[i*32 +: 32] = 15 - i;
    run_d16(v16, 1'b1, e16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
